mstream_matrix_framer: RTL and testbench
========================================

// Module: mstream_matrix_framer
// PURPOSE
//  Upstream producer for the Matrix Stream (mstream) interface. Accepts a flat element stream
//  over valid/ready and frames it as one matrix of cfg_rows x cfg_cols elements on the mstream
//  port, tagging start-of-row, end-of-row and end-of-matrix. Drives the bus monitored by the
//  mstream agent and interface checker. One registered pipeline stage, full throughput.
// PARAMETERS
//  DATA_WIDTH  32  element width in bits
//  DIM_W       8   width of row/column dimension fields (max dim = 2**DIM_W-1)
// PORTS
//  sys_clk    in   1           clock; all logic on rising edge
//  reset_n    in   1           asynchronous active-low reset
//  start      in   1           pulse: latch cfg_rows/cfg_cols, begin a matrix (ignored if busy)
//  cfg_rows   in   DIM_W       matrix rows
//  cfg_cols   in   DIM_W       matrix columns
//  busy       out  1           high from accepted start until the EOM beat leaves the output
//  done       out  1           1-cycle pulse on the cycle the EOM beat is accepted (out_rdy)
//  cfg_err    out  1           1-cycle pulse: start with cfg_rows==0 or cfg_cols==0
//  in_vld     in   1           input element valid
//  in_rdy     out  1           input element ready
//  in_data    in   DATA_WIDTH  input element
//  out_vld    out  1           mstream beat valid
//  out_rdy    in   1           mstream beat ready
//  out_data   out  DATA_WIDTH  mstream element
//  out_sol    out  1           first column of a row
//  out_eol    out  1           last column of a row
//  out_eom    out  1           last element of matrix (implies out_eol)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; dims 0. Reset mid-matrix drops the frame silently.
//  FSM IDLE: in_rdy=0. start & rows!=0 & cols!=0 -> latch dims, row=col=0, ACTIVE, busy=1 next cycle.
//   start with zero dim -> cfg_err pulse next cycle, stay IDLE, busy stays 0.
//  FSM ACTIVE: in_rdy = !out_vld | out_rdy (combinational on out_rdy). Input accept = in_vld&in_rdy.
//   On accept: out_data<=in_data, out_vld<=1, out_sol<=(col==0), out_eol<=(col==cols-1),
//   out_eom<=(col==cols-1 & row==rows-1). col increments; wraps to 0 with row++ at cols-1.
//   Accept of last element -> DRAIN.
//  FSM DRAIN: in_rdy=0; when out_vld&out_rdy -> done pulse that same cycle (combinational on
//   out_rdy), busy<=0, IDLE. start ignored in ACTIVE/DRAIN (no re-latch, no error).
//  Output stage: out_* stable while out_vld & !out_rdy. out_vld clears on out_rdy with no new
//   accept. Latency input->output = 1 cycle; back-to-back beats sustain 1 elem/cycle.
//  Counters width DIM_W; compare uses latched dims; 1x1 matrix: single beat with sol=eol=eom=1.
//  Back-to-back matrices: new start accepted in IDLE the cycle after done; no bubble required
//   beyond the single IDLE cycle.
//  in_data/out_data passed bit-exact, no arithmetic.
// TESTING
//  1) start rows=2 cols=3, in_vld=1 data 1..6, out_rdy=1 -> 6 beats consecutive, sol on 1,4;
//     eol on 3,6; eom on 6 only; done pulse with beat 6; busy 0 next cycle.
//  2) start rows=1 cols=1, data 0xA5 -> single beat sol=eol=eom=1, done, in_rdy=0 afterwards.
//  3) rows=2 cols=2, out_rdy toggled 1,0,0,1,... -> out_data held stable while stalled, no
//     element lost/duplicated, in_rdy=0 whenever out_vld & !out_rdy.
//  4) start rows=0 cols=4 -> cfg_err pulse, busy=0, in_rdy=0; start rows=3 cols=0 -> same.
//  5) reset_n asserted after 3 of 6 elements -> all outputs 0 immediately; new start 2x3 after
//     release frames cleanly from sol.
//  6) second start asserted during ACTIVE of 2x2 with cols=5 -> ignored; framing stays 2x2.

Source files
------------

// File: rtl/mstream_matrix_framer.sv
// mstream_matrix_framer
// Frames a flat valid/ready element stream into one cfg_rows x cfg_cols matrix
// on the mstream port. Each beat is tagged with start-of-row, end-of-row and
// end-of-matrix. A single registered output stage sustains one element per
// cycle. Elements pass through bit-exact.
module mstream_matrix_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_W      = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_W-1:0]      cfg_rows,
    input  logic [DIM_W-1:0]      cfg_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sol,
    output logic                  out_eol,
    output logic                  out_eom
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    logic [DIM_W-1:0] rows_q;
    logic [DIM_W-1:0] cols_q;
    logic [DIM_W-1:0] row_q;
    logic [DIM_W-1:0] col_q;

    logic last_col;
    logic last_row;
    logic accept;
    logic zero_dim;

    // Position compares always use the dimensions latched at start, never the live cfg inputs.
    assign last_col = (col_q == cols_q - DIM_W'(1));
    assign last_row = (row_q == rows_q - DIM_W'(1));
    assign zero_dim = (cfg_rows == '0) || (cfg_cols == '0);

    // The input is ready only while framing and only when the output register can take a beat.
    assign in_rdy = (state == ACTIVE) && (!out_vld || out_rdy);
    assign accept = in_vld && in_rdy;

    // done marks the cycle on which the end-of-matrix beat is taken downstream.
    assign done = (state == DRAIN) && out_vld && out_rdy;

    // Frame control: FSM, latched dimensions, row/column position, busy and cfg_err.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (zero_dim) begin
                            cfg_err <= 1'b1;
                        end else begin
                            rows_q <= cfg_rows;
                            cols_q <= cfg_cols;
                            row_q  <= '0;
                            col_q  <= '0;
                            busy   <= 1'b1;
                            state  <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                            if (last_row) begin
                                state <= DRAIN;
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_vld && out_rdy) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: load on accept, drop valid once the beat is taken, otherwise hold.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_sol  <= 1'b0;
            out_eol  <= 1'b0;
            out_eom  <= 1'b0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= in_data;
            out_sol  <= (col_q == '0);
            out_eol  <= last_col;
            out_eom  <= last_col && last_row;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mstream_matrix_framer.sv
// Directed testbench for mstream_matrix_framer: framing of 2x3, 1x1 and 2x2
// matrices, output stalls, zero-dimension start rejection, reset in the middle
// of a matrix and start ignored while busy.
module tb_mstream_matrix_framer;

    localparam int DATA_WIDTH = 32;
    localparam int DIM_W      = 8;

    logic                  sys_clk;
    logic                  reset_n;
    logic                  start;
    logic [DIM_W-1:0]      cfg_rows;
    logic [DIM_W-1:0]      cfg_cols;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sol;
    logic                  out_eol;
    logic                  out_eom;

    int n_asrt;
    int n_fail;

    mstream_matrix_framer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM_W      (DIM_W)
    ) dut (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .start    (start),
        .cfg_rows (cfg_rows),
        .cfg_cols (cfg_cols),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_sol  (out_sol),
        .out_eol  (out_eol),
        .out_eom  (out_eom)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Runs one full matrix at full throughput with out_rdy held high.
    // With hold set, start stays asserted (with a different cols value) while framing.
    task automatic run_frame(input int r, input int c, input logic [31:0] base, input bit hold);
        int n;
        n = r * c;
        start    = 1'b1;
        cfg_rows = DIM_W'(r);
        cfg_cols = DIM_W'(c);
        in_vld   = 1'b0;
        out_rdy  = 1'b1;
        tick();
        start = hold;
        if (hold) cfg_cols = DIM_W'(5);
        chk("frame_busy_set", 32'(busy), 32'd1);
        in_vld  = 1'b1;
        in_data = base;
        #1;
        chk("frame_in_rdy_first", 32'(in_rdy), 32'd1);
        for (int k = 0; k < n; k++) begin
            tick();
            chk("frame_out_vld", 32'(out_vld), 32'd1);
            chk("frame_out_data", out_data, base + 32'(k));
            chk("frame_sol", 32'(out_sol), 32'((k % c) == 0));
            chk("frame_eol", 32'(out_eol), 32'((k % c) == c - 1));
            chk("frame_eom", 32'(out_eom), 32'(k == n - 1));
            chk("frame_cfg_err", 32'(cfg_err), 32'd0);
            if (k < n - 1) begin
                in_data = base + 32'(k + 1);
            end else begin
                in_vld = 1'b0;
                start  = 1'b0;
            end
            #1;
            chk("frame_done", 32'(done), 32'(k == n - 1));
            chk("frame_in_rdy", 32'(in_rdy), 32'(k < n - 1));
        end
        tick();
        chk("frame_busy_clear", 32'(busy), 32'd0);
        chk("frame_out_vld_clear", 32'(out_vld), 32'd0);
        chk("frame_done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        n_asrt   = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        cfg_rows = '0;
        cfg_cols = '0;
        in_vld   = 1'b0;
        in_data  = '0;
        out_rdy  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flags", {29'd0, out_sol, out_eol, out_eom}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 2x3 matrix, data 1..6
        run_frame(2, 3, 32'd1, 1'b0);

        // 1x1 matrix started in the IDLE cycle right after the previous done
        start    = 1'b1;
        cfg_rows = 8'd1;
        cfg_cols = 8'd1;
        in_vld   = 1'b1;
        in_data  = 32'hA5;
        out_rdy  = 1'b1;
        #1;
        chk("one_idle_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        start = 1'b0;
        #1;
        chk("one_busy", 32'(busy), 32'd1);
        chk("one_in_rdy", 32'(in_rdy), 32'd1);
        tick();
        chk("one_data", out_data, 32'hA5);
        chk("one_flags", {28'd0, out_vld, out_sol, out_eol, out_eom}, 32'hF);
        in_vld = 1'b0;
        #1;
        chk("one_done", 32'(done), 32'd1);
        chk("one_in_rdy_drain", 32'(in_rdy), 32'd0);
        tick();
        chk("one_busy_clear", 32'(busy), 32'd0);
        chk("one_out_vld_clear", 32'(out_vld), 32'd0);
        chk("one_in_rdy_idle", 32'(in_rdy), 32'd0);

        // 2x2 matrix with output stalls
        start    = 1'b1;
        cfg_rows = 8'd2;
        cfg_cols = 8'd2;
        in_vld   = 1'b0;
        out_rdy  = 1'b1;
        tick();
        start   = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'h11;
        tick();
        chk("stall_b1_data", out_data, 32'h11);
        chk("stall_b1_sol", 32'(out_sol), 32'd1);
        out_rdy = 1'b0;
        in_data = 32'h22;
        #1;
        chk("stall_in_rdy_a", 32'(in_rdy), 32'd0);
        tick();
        chk("stall_hold1_vld", 32'(out_vld), 32'd1);
        chk("stall_hold1_data", out_data, 32'h11);
        chk("stall_hold1_sol", 32'(out_sol), 32'd1);
        chk("stall_in_rdy_b", 32'(in_rdy), 32'd0);
        tick();
        chk("stall_hold2_data", out_data, 32'h11);
        out_rdy = 1'b1;
        #1;
        chk("stall_in_rdy_c", 32'(in_rdy), 32'd1);
        tick();
        chk("stall_b2_data", out_data, 32'h22);
        chk("stall_b2_flags", {29'd0, out_sol, out_eol, out_eom}, 32'b010);
        in_data = 32'h33;
        tick();
        chk("stall_b3_data", out_data, 32'h33);
        chk("stall_b3_flags", {29'd0, out_sol, out_eol, out_eom}, 32'b100);
        out_rdy = 1'b0;
        in_data = 32'h44;
        #1;
        chk("stall_in_rdy_d", 32'(in_rdy), 32'd0);
        chk("stall_done_held", 32'(done), 32'd0);
        tick();
        chk("stall_hold3_data", out_data, 32'h33);
        out_rdy = 1'b1;
        tick();
        chk("stall_b4_data", out_data, 32'h44);
        chk("stall_b4_flags", {29'd0, out_sol, out_eol, out_eom}, 32'b011);
        in_vld = 1'b0;
        #1;
        chk("stall_done", 32'(done), 32'd1);
        tick();
        chk("stall_busy_clear", 32'(busy), 32'd0);
        chk("stall_out_vld_clear", 32'(out_vld), 32'd0);

        // Zero-dimension starts
        start    = 1'b1;
        cfg_rows = 8'd0;
        cfg_cols = 8'd4;
        tick();
        start = 1'b0;
        chk("zr_cfg_err", 32'(cfg_err), 32'd1);
        chk("zr_busy", 32'(busy), 32'd0);
        chk("zr_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        chk("zr_cfg_err_pulse", 32'(cfg_err), 32'd0);
        start    = 1'b1;
        cfg_rows = 8'd3;
        cfg_cols = 8'd0;
        tick();
        start = 1'b0;
        chk("zc_cfg_err", 32'(cfg_err), 32'd1);
        chk("zc_busy", 32'(busy), 32'd0);
        chk("zc_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        chk("zc_cfg_err_pulse", 32'(cfg_err), 32'd0);

        // Start ignored while busy: 2x2 frame with start held and cols=5
        run_frame(2, 2, 32'h100, 1'b1);

        // Reset after 3 of 6 elements, then a clean 2x3 frame
        start    = 1'b1;
        cfg_rows = 8'd2;
        cfg_cols = 8'd3;
        out_rdy  = 1'b1;
        tick();
        start   = 1'b0;
        in_vld  = 1'b1;
        in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        in_data = 32'h23;
        tick();
        chk("mid_beat3_data", out_data, 32'h23);
        in_vld  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_flags", {28'd0, out_sol, out_eol, out_eom, cfg_err}, 32'd0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run_frame(2, 3, 32'h40, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
